// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared types for the code lock.
//   state_e - 3-bit FSM state type; the enum values are the encodings seen on
//             state_out.
//   max3    - helper used to size the shared timer.
package code_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_CHECK   = 3'd2,
    ST_GRANTED = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/code_lock_timer.sv
// code_lock_timer: loadable down-counter with a zero flag.
// One counter is shared by the GRANTED and LOCKOUT durations and by the
// inter-digit entry timeout, because only one of them is ever running.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (count -> 0)
//   load         - load load_val this cycle (wins over dec)
//   load_val     - value to load
//   dec          - decrement by one; the count holds at zero
//   done         - count is zero
module code_lock_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          done
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (dec && !done)      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// code_lock_fsm: keypad code lock.
// Digits are shifted into an entry buffer. Once NUM_DIGITS digits have arrived,
// a one-cycle CHECK compares the buffer with code_ref. A match opens the door
// for OPEN_CYCLES cycles. A mismatch counts a failure, and after MAX_FAILS
// consecutive failures the lock enters a LOCKOUT of LOCKOUT_CYCLES cycles.
// Build option: define CODE_LOCK_LOCKOUT_EN to enable failure counting and
// lockout. Without it, a mismatch always returns to IDLE, locked_out stays 0,
// and fail_cnt stays 0.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   digit_valid       - digit_in carries a digit this cycle
//   digit_in          - entered digit
//   clear             - abort the entry in progress (COLLECT only)
//   code_ref          - expected code, first digit in the MS digit
//   open_access_door  - 1 while GRANTED
//   locked_out        - 1 while LOCKOUT
//   state_out         - state register
//   fail_cnt          - consecutive failed checks
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int NUM_DIGITS     = 4,
  parameter int OPEN_CYCLES    = 15,
  parameter int ENTRY_TIMEOUT  = 32,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             digit_valid,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             clear,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]    code_ref,
  output logic                             open_access_door,
  output logic                             locked_out,
  output logic [2:0]                       state_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int BW = NUM_DIGITS * DIGIT_W;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(max3(OPEN_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT)) + 1;

  // Each duration loads N-1: the state then lasts N cycles and leaves on
  // the cycle where the counter reads zero.
  localparam logic [TW-1:0] T_OPEN  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] T_ENTRY = TW'(ENTRY_TIMEOUT - 1);
`ifdef CODE_LOCK_LOCKOUT_EN
  localparam logic [TW-1:0] T_LOCK  = TW'(LOCKOUT_CYCLES - 1);
`endif

  state_e        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fail_q, fail_d;

  logic          tmr_load, tmr_dec, tmr_done;
  logic [TW-1:0] tmr_val;

`ifdef CODE_LOCK_LOCKOUT_EN
  logic [FW-1:0] fail_inc;
  assign fail_inc = fail_q + 1'b1;
`endif

  code_lock_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (digit_valid) begin
          buf_d    = BW'(digit_in);
          cnt_d    = CW'(1);
          tmr_load = 1'b1;
          tmr_val  = T_ENTRY;
          state_d  = (NUM_DIGITS == 1) ? ST_CHECK : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (clear) begin
          state_d = ST_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (digit_valid) begin
          // Shift left and append: the first digit ends up in the MS slot.
          buf_d    = (buf_q << DIGIT_W) | BW'(digit_in);
          cnt_d    = cnt_q + 1'b1;
          tmr_load = 1'b1;
          tmr_val  = T_ENTRY;
          if (cnt_q == CW'(NUM_DIGITS - 1)) state_d = ST_CHECK;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_CHECK: begin
        cnt_d = '0;
        if (buf_q == code_ref) begin
          state_d  = ST_GRANTED;
          fail_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = T_OPEN;
        end else begin
`ifdef CODE_LOCK_LOCKOUT_EN
          fail_d = fail_inc;
          if (fail_inc == FW'(MAX_FAILS)) begin
            state_d  = ST_LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = T_LOCK;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end

      ST_GRANTED: begin
        if (tmr_done) state_d = ST_IDLE;
        else          tmr_dec = 1'b1;
      end

`ifdef CODE_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
`endif

      // Unused encodings (and LOCKOUT when lockout is compiled out) recover.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
    end
  end

  assign state_out        = state_q;
  assign open_access_door = (state_q == ST_GRANTED);
  assign locked_out       = (state_q == ST_LOCKOUT);
  assign fail_cnt         = fail_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm with default parameters and code_ref = 16'h429B.
// Stimulus pushes {cycle, state, fail_cnt} records into a scoreboard queue.
// The monitor checks the outputs on every falling edge: at the cycle of each
// record the outputs must match that record, and between records they must
// hold the values of the last record. The bench follows CODE_LOCK_LOCKOUT_EN.
module tb_code_lock_fsm;

  localparam int OPEN = 15;
  localparam int LOCK = 64;
  localparam int TMO  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit_in = '0;
  logic        clear = 1'b0;
  logic [15:0] code_ref = 16'h429B;
  logic        open_access_door, locked_out;
  logic [2:0]  state_out;
  logic [1:0]  fail_cnt;

  code_lock_fsm dut (
    .clk              (clk),
    .rst              (rst),
    .digit_valid      (digit_valid),
    .digit_in         (digit_in),
    .clear            (clear),
    .code_ref         (code_ref),
    .open_access_door (open_access_door),
    .locked_out       (locked_out),
    .state_out        (state_out),
    .fail_cnt         (fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    st;
    int    fail;
    string tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  logic [6:0] exp_v, got_v;

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL %s: record for cycle %0d not reached in order (now %0d)",
                 sb[0].tag, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) cur = sb.pop_front();
      exp_v = {3'(cur.st), cur.st == 3, cur.st == 4, 2'(cur.fail)};
      got_v = {state_out, open_access_door, locked_out, fail_cnt};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL %s @cyc %0d: got state=%0d door=%0b lock=%0b fail=%0d, want state=%0d door=%0b lock=%0b fail=%0d",
                 cur.tag, cyc, state_out, open_access_door, locked_out, fail_cnt,
                 cur.st, cur.st == 3, cur.st == 4, cur.fail);
      end
    end
  end

  task automatic push(input int c, input int st, input int f, input string tag);
    exp_t e;
    e.cyc = c; e.st = st; e.fail = f; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Drive the first n digits of code (MS digit first) on consecutive cycles.
  task automatic enter(input logic [15:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      digit_valid = 1'b1;
      digit_in    = code[15-4*i -: 4];
      tick();
    end
    digit_valid = 1'b0;
  endtask

  // Full four-digit entry. fb/fa: fail_cnt before/after CHECK; nxt: state after CHECK.
  task automatic run_code(input logic [15:0] code, input int fb, input int fa,
                          input int nxt, input string tag);
    int c0, done_c;
    c0 = cyc;
    push(c0 + 1, 1, fb, {tag, " collect"});
    push(c0 + 4, 2, fb, {tag, " check"});
    push(c0 + 5, nxt, fa, {tag, " result"});
    done_c = c0 + 5;
    if (nxt == 3) begin push(c0 + 5 + OPEN, 0, 0, {tag, " door close"}); done_c = c0 + 5 + OPEN; end
    if (nxt == 4) begin push(c0 + 5 + LOCK, 0, 0, {tag, " lockout end"}); done_c = c0 + 5 + LOCK; end
    enter(code, 4);
    // These inputs arrive during CHECK, GRANTED, or LOCKOUT and must be ignored.
    if (nxt != 0) begin
      repeat (6) begin
        digit_valid = 1'b1; clear = 1'b1; digit_in = 4'h4;
        tick();
      end
      digit_valid = 1'b0; clear = 1'b0;
    end
    wait_until(done_c + 2);
  endtask

  task automatic timeout_case(input int f);
    int c0;
    c0 = cyc;
    push(c0 + 1, 1, f, "timeout collect");
    push(c0 + 2 + TMO, 0, f, "timeout idle");
    enter(16'h4200, 2);
    wait_until(c0 + 2 + TMO + 2);
  endtask

  task automatic clear_case(input int f);
    int c0;
    c0 = cyc;
    push(c0 + 1, 1, f, "clear collect");
    push(c0 + 3, 0, f, "clear wins");
    enter(16'h4200, 2);
    digit_valid = 1'b1; clear = 1'b1; digit_in = 4'h9;
    tick();
    digit_valid = 1'b0; clear = 1'b0;
    wait_until(c0 + 5);
  endtask

  task automatic reset_granted_case();
    int c0;
    c0 = cyc;
    push(c0 + 1, 1, 0, "rstg collect");
    push(c0 + 4, 2, 0, "rstg check");
    push(c0 + 5, 3, 0, "rstg granted");
    push(c0 + 10, 0, 0, "rstg reset");
    enter(16'h429B, 4);
    wait_until(c0 + 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_until(c0 + 13);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push(cyc, 0, 0, "reset");
    mon_en = 1'b1;

    run_code(16'h429B, 0, 0, 3, "open");
`ifdef CODE_LOCK_LOCKOUT_EN
    run_code(16'h429A, 0, 1, 0, "wrong1");
    timeout_case(1);
    run_code(16'h429B, 1, 0, 3, "open after timeout");
    run_code(16'h429A, 0, 1, 0, "lk1");
    run_code(16'h429A, 1, 2, 0, "lk2");
    run_code(16'h429A, 2, 3, 4, "lk3");
`else
    run_code(16'h429A, 0, 0, 0, "wrong1");
    run_code(16'h429A, 0, 0, 0, "wrong2");
    run_code(16'h429A, 0, 0, 0, "wrong3");
    run_code(16'h429A, 0, 0, 0, "wrong4");
    timeout_case(0);
    run_code(16'h429B, 0, 0, 3, "open after wrongs");
`endif
    clear_case(0);
    run_code(16'h429B, 0, 0, 3, "open after clear");
    reset_granted_case();

    repeat (3) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: %0d records left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
